// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state type and small op-decode helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    // Ops that occupy the iterative datapath (codes 0..3).
    function automatic logic is_muldiv(input logic [2:0] op);
        return op[2] == 1'b0;
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling shared by multiply and divide: operand
// magnitudes at launch, and sign correction of the raw result at FIX.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             sign_a,
    output logic             sign_b,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    input  logic             fix_mul,
    input  logic             neg_res,
    input  logic             neg_rem,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    logic [2*WIDTH-1:0] prod_neg;

    // Magnitudes of the launch operands; unsigned ops pass through unchanged.
    always_comb begin
        sign_a = is_signed & a[WIDTH-1];
        sign_b = is_signed & b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // Sign correction: full 2*WIDTH negate for products, separate
    // quotient/remainder negates for divides.
    always_comb begin
        prod_neg = -{raw_hi, raw_lo};
        fix_hi   = raw_hi;
        fix_lo   = raw_lo;
        if (fix_mul) begin
            if (neg_res) begin
                {fix_hi, fix_lo} = prod_neg;
            end
        end else begin
            if (neg_res) begin
                fix_lo = -raw_lo;
            end
            if (neg_rem) begin
                fix_hi = -raw_hi;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiply is radix-2 shift-add, divide is restoring; both work on
// magnitudes for WIDTH cycles, then a FIX cycle applies signs and
// writes HI/LO. MTHI/MTLO write HI/LO directly while idle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             op_mul;
    logic             neg_res;
    logic             neg_rem;
    logic             zero_div;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   acc_hi_next;
    logic [WIDTH-1:0] acc_lo_next;

    logic             accept;
    logic             launch;
    logic             mt_hi;
    logic             mt_lo;
    logic             launch_mul;
    logic             op_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign busy       = (state != IDLE);
    assign accept     = start & ~busy & ~flush;
    assign launch     = accept & is_muldiv(op);
    assign mt_hi      = accept & (op == OP_MTHI);
    assign mt_lo      = accept & (op == OP_MTLO);
    assign launch_mul = is_mul_op(op);
    assign op_signed  = is_signed_op(op);

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .a         (a),
        .b         (b),
        .is_signed (op_signed),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .fix_mul   (op_mul),
        .neg_res   (neg_res),
        .neg_rem   (neg_rem),
        .raw_hi    (acc_hi[WIDTH-1:0]),
        .raw_lo    (acc_lo),
        .fix_hi    (fix_hi),
        .fix_lo    (fix_lo)
    );

    // Next-state logic; flush overrides every transition.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // One iteration step: shift-add for multiply, trial subtract for divide.
    always_comb begin
        addend      = acc_lo[0] ? opnd : '0;
        mul_sum     = acc_hi + {1'b0, addend};
        div_shift   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_trial   = div_shift - {1'b0, opnd};
        acc_hi_next = div_shift;
        acc_lo_next = {acc_lo[WIDTH-2:0], 1'b0};
        if (op_mul) begin
            acc_hi_next = {1'b0, mul_sum[WIDTH:1]};
            acc_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            acc_hi_next = div_trial;
            acc_lo_next = {acc_lo[WIDTH-2:0], 1'b1};
        end
    end

    // Operand/accumulator datapath: loaded at launch, stepped in RUN.
    // NOTE: these registers have no reset; nothing reads them before a launch loads them.
    always_ff @(posedge clk) begin
        if (launch) begin
            op_mul   <= launch_mul;
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a & ~launch_mul;
            zero_div <= ~launch_mul & (b == '0);
            opnd     <= launch_mul ? mag_a : mag_b;
            acc_hi   <= '0;
            acc_lo   <= launch_mul ? mag_b : mag_a;
        end else if (state == RUN) begin
            acc_hi   <= acc_hi_next;
            acc_lo   <= acc_lo_next;
        end
    end

    // Control state, iteration counter, HI/LO and the done/div0 pulses.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            div0  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            div0  <= 1'b0;
            if (flush) begin
                cnt <= '0;
            end else if (launch) begin
                cnt <= CNT_W'(WIDTH);
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            if ((state == FIX) && !flush) begin
                hi   <= fix_hi;
                lo   <= fix_lo;
                done <= 1'b1;
                div0 <= zero_div;
            end else if (mt_hi) begin
                hi <= a;
            end else if (mt_lo) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a 32-bit and an 8-bit instance,
// a table of directed vectors, hand-written flush/reset/busy sequences,
// and random operations checked against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  start_v;
    logic [1:0]  flush_v;
    logic [2:0]  op_v [2];
    logic [31:0] a_v  [2];
    logic [31:0] b_v  [2];

    logic        busy32, done32, div032;
    logic [31:0] hi32, lo32;
    logic        busy8, done8, div08;
    logic [7:0]  hi8, lo8;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_v[0]),
        .op    (op_v[0]),
        .a     (a_v[0]),
        .b     (b_v[0]),
        .flush (flush_v[0]),
        .busy  (busy32),
        .done  (done32),
        .div0  (div032),
        .hi    (hi32),
        .lo    (lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_v[1]),
        .op    (op_v[1]),
        .a     (a_v[1][7:0]),
        .b     (b_v[1][7:0]),
        .flush (flush_v[1]),
        .busy  (busy8),
        .done  (done8),
        .div0  (div08),
        .hi    (hi8),
        .lo    (lo8)
    );

    function automatic logic rd_busy(input int u);
        return (u == 0) ? busy32 : busy8;
    endfunction
    function automatic logic rd_done(input int u);
        return (u == 0) ? done32 : done8;
    endfunction
    function automatic logic rd_div0(input int u);
        return (u == 0) ? div032 : div08;
    endfunction
    function automatic logic [31:0] rd_hi(input int u);
        return (u == 0) ? hi32 : {24'd0, hi8};
    endfunction
    function automatic logic [31:0] rd_lo(input int u);
        return (u == 0) ? lo32 : {24'd0, lo8};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Extend a w-bit operand to 64 bits, sign- or zero-extended.
    function automatic logic [63:0] ext(input logic [31:0] v, input int w, input bit sgn);
        logic [63:0] m;
        logic [63:0] x;
        m = (64'd1 << w) - 64'd1;
        x = {32'd0, v} & m;
        if (sgn && x[w-1]) x = x | ~m;
        return x;
    endfunction

    // Reference: plain 64-bit arithmetic with the divide-by-zero rules.
    task automatic model(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic [63:0] m, xa, xb, p;
        longint      q, r;
        bit          sgn;
        m   = (64'd1 << w) - 64'd1;
        sgn = (op == OP_MULT) || (op == OP_DIV);
        xa  = ext(a, w, sgn);
        xb  = ext(b, w, sgn);
        dz  = 1'b0;
        if ((op == OP_MULT) || (op == OP_MULTU)) begin
            p  = xa * xb;
            lo = 32'(p & m);
            hi = 32'((p >> w) & m);
        end else if (xb == 64'd0) begin
            dz = 1'b1;
            lo = (sgn && xa[63]) ? 32'd1 : 32'(m);
            hi = 32'(xa & m);
        end else begin
            q  = longint'(xa) / longint'(xb);
            r  = longint'(xa) % longint'(xb);
            lo = 32'(64'(q) & m);
            hi = 32'(64'(r) & m);
        end
    endtask

    // Issue one op from an idle unit and wait (bounded) until busy falls.
    task automatic run_op(input int u, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                          output logic dn, output int cyc);
        start_v[u] = 1'b1;
        op_v[u]    = op;
        a_v[u]     = a;
        b_v[u]     = b;
        tick();
        start_v[u] = 1'b0;
        cyc = 0;
        while (rd_busy(u) && cyc < 100) begin
            cyc++;
            tick();
        end
        dn = rd_done(u);
        dz = rd_div0(u);
        hi = rd_hi(u);
        lo = rd_lo(u);
    endtask

    typedef struct {
        int          u;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        logic [31:0] hi, lo, ehi, elo, ra, rb;
        logic        dz, dn, edz, saw_done;
        logic [2:0]  rop;
        int          cyc, w, sel;

        vecs[0]  = '{0, OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
        vecs[1]  = '{0, OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vecs[2]  = '{0, OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{0, OP_DIVU,  32'd10,       32'd0,        32'h0000000A, 32'hFFFFFFFF, 1'b1, 33};
        vecs[4]  = '{0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[5]  = '{0, OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[6]  = '{1, OP_MULTU, 32'd4,        32'd4,        32'd0,        32'd16,       1'b0, 9};
        vecs[7]  = '{1, OP_MULT,  32'h80,       32'h80,       32'h40,       32'h00,       1'b0, 9};
        vecs[8]  = '{1, OP_DIV,   32'hF6,       32'd0,        32'hF6,       32'h01,       1'b1, 9};
        vecs[9]  = '{1, OP_DIV,   32'h80,       32'hFF,       32'h00,       32'h80,       1'b0, 9};
        vecs[10] = '{0, OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
        vecs[11] = '{1, OP_DIVU,  32'hFF,       32'h10,       32'h0F,       32'h0F,       1'b0, 9};

        rst_n   = 1'b0;
        start_v = '0;
        flush_v = '0;
        for (int u = 0; u < 2; u++) begin
            op_v[u] = OP_MULT;
            a_v[u]  = '0;
            b_v[u]  = '0;
        end

        // Reset state of both instances.
        repeat (2) tick();
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset busy u%0d", u), 64'(rd_busy(u)), 64'd0);
            check($sformatf("reset done u%0d", u), 64'(rd_done(u)), 64'd0);
            check($sformatf("reset div0 u%0d", u), 64'(rd_div0(u)), 64'd0);
            check($sformatf("reset hi u%0d", u), 64'(rd_hi(u)), 64'd0);
            check($sformatf("reset lo u%0d", u), 64'(rd_lo(u)), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // MTHI at idle: one-cycle write, no busy, no done.
        run_op(0, OP_MTHI, 32'h12345678, 32'd0, hi, lo, dz, dn, cyc);
        check("mthi hi", 64'(hi), 64'h12345678);
        check("mthi busy cycles", 64'(cyc), 64'd0);
        check("mthi done", 64'(dn), 64'd0);

        // DIVU 100/7 with a second start during busy that must be ignored.
        start_v[0] = 1'b1; op_v[0] = OP_DIVU; a_v[0] = 32'd100; b_v[0] = 32'd7;
        tick();
        cyc = 0;
        while (busy32 && cyc < 100) begin
            cyc++;
            start_v[0] = (cyc == 4);
            b_v[0]     = (cyc == 4) ? 32'd1 : 32'd7;
            tick();
        end
        start_v[0] = 1'b0;
        check("ign busy cycles", 64'(cyc), 64'd33);
        check("ign done", 64'(done32), 64'd1);
        check("ign lo", 64'(lo32), 64'd14);
        check("ign hi", 64'(hi32), 64'd2);
        tick();
        check("ign done pulse", 64'(done32), 64'd0);
        check("ign no requeue", 64'(busy32), 64'd0);

        // Preload HI/LO, then flush a MULT mid-flight.
        run_op(0, OP_MTHI, 32'd1, 32'd0, hi, lo, dz, dn, cyc);
        run_op(0, OP_MTLO, 32'd2, 32'd0, hi, lo, dz, dn, cyc);
        check("preload hi", 64'(hi), 64'd1);
        check("preload lo", 64'(lo), 64'd2);
        start_v[0] = 1'b1; op_v[0] = OP_MULT; a_v[0] = 32'd6; b_v[0] = 32'd7;
        tick();
        start_v[0] = 1'b0;
        repeat (8) tick();
        check("flush busy before", 64'(busy32), 64'd1);
        flush_v[0] = 1'b1;
        tick();
        flush_v[0] = 1'b0;
        check("flush busy after", 64'(busy32), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            saw_done |= done32 | busy32;
            tick();
        end
        check("flush no done", 64'(saw_done), 64'd0);
        check("flush hi kept", 64'(hi32), 64'd1);
        check("flush lo kept", 64'(lo32), 64'd2);

        // Flush in the same cycle as start cancels the launch.
        start_v[0] = 1'b1; flush_v[0] = 1'b1; op_v[0] = OP_MULTU; a_v[0] = 32'd3; b_v[0] = 32'd3;
        tick();
        start_v[0] = 1'b0; flush_v[0] = 1'b0;
        check("flush+start busy", 64'(busy32), 64'd0);

        // Codes 6 and 7 are no-ops.
        run_op(0, 3'd6, 32'hDEAD, 32'd1, hi, lo, dz, dn, cyc);
        check("noop6 busy cycles", 64'(cyc), 64'd0);
        run_op(0, 3'd7, 32'hBEEF, 32'd1, hi, lo, dz, dn, cyc);
        check("noop hi/lo", {hi, lo}, {32'd1, 32'd2});

        // Asynchronous reset mid-divide clears everything immediately.
        start_v[0] = 1'b1; op_v[0] = OP_DIV; a_v[0] = 32'd9; b_v[0] = 32'd3;
        tick();
        start_v[0] = 1'b0;
        repeat (10) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst busy", 64'(busy32), 64'd0);
        check("arst hi", 64'(hi32), 64'd0);
        check("arst lo", 64'(lo32), 64'd0);
        check("arst done", 64'(done32), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].u, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dz, dn, cyc);
            check($sformatf("vec%0d busy cycles", i), 64'(cyc), 64'(vecs[i].cyc));
            check($sformatf("vec%0d done", i), 64'(dn), 64'd1);
            check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d div0", i), 64'(dz), 64'(vecs[i].dz));
            tick();
            check($sformatf("vec%0d pulse end", i), 64'({rd_done(vecs[i].u), rd_div0(vecs[i].u)}), 64'd0);
        end

        // Random operations against the reference model.
        for (int u = 0; u < 2; u++) begin
            w = (u == 0) ? 32 : 8;
            for (int k = 0; k < 30; k++) begin
                rop = 3'($urandom_range(0, 3));
                ra  = $urandom;
                rb  = $urandom;
                sel = $urandom_range(0, 7);
                if (sel == 0) begin
                    rb = 32'd0;
                end else if (sel == 1) begin
                    ra = 32'd1 << (w - 1);
                    rb = '1;
                end else if (sel == 2) begin
                    rb = 32'($urandom_range(1, 15));
                end
                if (u == 1) begin
                    ra = ra & 32'hFF;
                    rb = rb & 32'hFF;
                end
                model(w, rop, ra, rb, ehi, elo, edz);
                run_op(u, rop, ra, rb, hi, lo, dz, dn, cyc);
                check($sformatf("rnd u%0d op%0d %0h,%0h busy", u, rop, ra, rb), 64'(cyc), 64'(w + 1));
                check($sformatf("rnd u%0d op%0d %0h,%0h hi", u, rop, ra, rb), 64'(hi), 64'(ehi));
                check($sformatf("rnd u%0d op%0d %0h,%0h lo", u, rop, ra, rb), 64'(lo), 64'(elo));
                check($sformatf("rnd u%0d op%0d %0h,%0h div0", u, rop, ra, rb), 64'({dn, dz}), 64'({1'b1, edz}));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
